// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and defaults for the memory arbiter
package mem_arb_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_I_FILL  = 3'd1;
    localparam logic [2:0] S_D_FILL  = 3'd2;
    localparam logic [2:0] S_D_WRITE = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_I_FILL  = S_I_FILL,
        ST_D_FILL  = S_D_FILL,
        ST_D_WRITE = S_D_WRITE,
        ST_DRAIN   = S_DRAIN
    } arb_state_t;

    localparam int DEF_BEATS   = 8;
    localparam int DEF_LATENCY = 4;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - register cell with write enable and synchronous active-high clear
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (wen) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_arbiter_beat_counter.sv
// rtl/mem_arbiter_beat_counter.sv - up/down counter with clear, load and terminal-count flag
module beat_counter #(
    parameter int               WIDTH      = 3,
    parameter bit               COUNT_DOWN = 1'b0,
    parameter logic [WIDTH-1:0] TERMINAL   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;

    // Up-counting wraps at TERMINAL so non-power-of-two beat counts still cycle cleanly.
    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_value;
        end else if (en) begin
            if (COUNT_DOWN) begin
                count_next = count - ONE;
            end else if (count == TERMINAL) begin
                count_next = '0;
            end else begin
                count_next = count + ONE;
            end
        end
    end

    dff #(.WIDTH(WIDTH)) u_count (
        .clk (clk),
        .rst (~rst_n),
        .wen (clr | load | en),
        .d   (count_next),
        .q   (count)
    );

    assign tc = (count == TERMINAL);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache arbiter for the shared main memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int BEATS   = DEF_BEATS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_grant,
    output logic        i_data_valid,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_grant,
    output logic        d_data_valid,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_data_valid
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [BW-1:0] BEAT_LAST  = BW'(BEATS - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(LATENCY - 2);

    arb_state_t state;
    logic       last_read_winner;
    logic       in_fill;
    logic       beat_en;
    logic       beat_tc;
    logic       fill_done;
    logic       drain_tc;

    assign in_fill   = (state == ST_I_FILL) || (state == ST_D_FILL);
    assign beat_en   = in_fill & mem_data_valid;
    assign fill_done = beat_en & beat_tc;

    beat_counter #(
        .WIDTH      (BW),
        .COUNT_DOWN (1'b0),
        .TERMINAL   (BEAT_LAST)
    ) u_beats (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (beat_en),
        .clr        (state == ST_IDLE),
        .load       (1'b0),
        .load_value ('0),
        .tc         (beat_tc)
    );

    // Drain covers the LATENCY-1 cycles in which reads issued late in the fill can still return.
    beat_counter #(
        .WIDTH      (DW),
        .COUNT_DOWN (1'b1),
        .TERMINAL   ('0)
    ) u_drain (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state == ST_DRAIN),
        .clr        (1'b0),
        .load       (fill_done),
        .load_value (DRAIN_LOAD),
        .tc         (drain_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            i_grant          <= 1'b0;
            d_grant          <= 1'b0;
            last_read_winner <= OWNER_I;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (d_req && d_wr) begin
                        state   <= ST_D_WRITE;
                        d_grant <= 1'b1;
                    end else if (d_req && (!i_req || last_read_winner == OWNER_I)) begin
                        state   <= ST_D_FILL;
                        d_grant <= 1'b1;
                    end else if (i_req) begin
                        state   <= ST_I_FILL;
                        i_grant <= 1'b1;
                    end
                end
                ST_D_WRITE: begin
                    state   <= ST_IDLE;
                    d_grant <= 1'b0;
                end
                ST_I_FILL, ST_D_FILL: begin
                    if (fill_done) begin
                        state            <= ST_DRAIN;
                        i_grant          <= 1'b0;
                        d_grant          <= 1'b0;
                        last_read_winner <= (state == ST_D_FILL) ? OWNER_D : OWNER_I;
                    end
                end
                ST_DRAIN: begin
                    if (drain_tc) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    i_grant <= 1'b0;
                    d_grant <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        i_data_valid = 1'b0;
        d_data_valid = 1'b0;
        case (state)
            ST_D_WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
            end
            ST_I_FILL: begin
                mem_enable   = i_req;
                mem_addr     = i_addr;
                i_data_valid = mem_data_valid;
            end
            ST_D_FILL: begin
                mem_enable   = d_req;
                mem_addr     = d_addr;
                d_data_valid = mem_data_valid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int LATENCY = 4;
    localparam int BEATS   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_grant;
    logic        i_data_valid;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_grant;
    logic        d_data_valid;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_data_valid;

    logic [LATENCY-1:0] mem_pipe = '0;
    logic               inject = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(LATENCY), .BEATS(BEATS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_grant        (i_grant),
        .i_data_valid   (i_data_valid),
        .d_req          (d_req),
        .d_wr           (d_wr),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_grant        (d_grant),
        .d_data_valid   (d_data_valid),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_data_valid (mem_data_valid)
    );

    // Memory: every read strobe comes back LATENCY cycles later; inject forces an extra return.
    always @(posedge clk) begin
        if (!rst_n) mem_pipe <= '0;
        else        mem_pipe <= {mem_pipe[LATENCY-2:0], mem_enable & ~mem_wr};
    end
    assign mem_data_valid = mem_pipe[LATENCY-1] | inject;

    // Transaction-level reference: who owns the memory, beats received, drain cycles left.
    int m_fill = 0;   // 0 none, 1 I-cache line, 2 D-cache line
    bit m_store = 0;
    int m_beats = 0;
    int m_drain = 0;
    int m_last = 1;   // last read winner: 1 I, 2 D

    logic        e_i_grant, e_d_grant, e_mem_enable, e_mem_wr, e_i_dv, e_d_dv;
    logic [15:0] e_mem_addr, e_mem_wdata;

    function automatic void model_expect();
        e_i_grant    = (m_fill == 1);
        e_d_grant    = (m_fill == 2) || m_store;
        e_mem_enable = m_store || (m_fill == 1 && i_req) || (m_fill == 2 && d_req);
        e_mem_wr     = m_store;
        e_mem_addr   = (m_store || m_fill == 2) ? d_addr : ((m_fill == 1) ? i_addr : 16'h0);
        e_mem_wdata  = m_store ? d_wdata : 16'h0;
        e_i_dv       = (m_fill == 1) && mem_data_valid;
        e_d_dv       = (m_fill == 2) && mem_data_valid;
    endfunction

    function automatic void model_advance();
        if (!rst_n) begin
            m_fill = 0; m_store = 0; m_beats = 0; m_drain = 0; m_last = 1;
        end else if (m_store) begin
            m_store = 0;
        end else if (m_fill != 0) begin
            if (mem_data_valid) begin
                m_beats++;
                if (m_beats == BEATS) begin
                    m_last = m_fill; m_fill = 0; m_beats = 0; m_drain = LATENCY - 1;
                end
            end
        end else if (m_drain > 0) begin
            m_drain--;
        end else if (d_req && d_wr) begin
            m_store = 1;
        end else if (d_req && i_req) begin
            m_fill = (m_last == 1) ? 2 : 1;
        end else if (d_req) begin
            m_fill = 2;
        end else if (i_req) begin
            m_fill = 1;
        end
    endfunction

    task automatic tick();
        model_advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; inject = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
        i_addr = 16'h1234; d_addr = 16'h5678; d_wdata = 16'h9ABC;
        tick();
        tick();
        #1;
        checks++; if (i_grant !== 1'b0) begin errors++; $display("FAIL reset_i_grant: got %b expected 0", i_grant); end
        checks++; if (d_grant !== 1'b0) begin errors++; $display("FAIL reset_d_grant: got %b expected 0", d_grant); end
        checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_enable: got %b expected 0", mem_enable); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0000", mem_wdata); end
        checks++; if ({i_data_valid, d_data_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b expected 00", {i_data_valid, d_data_valid}); end
        do_reset();
    endtask

    task automatic test_lone_i_fill();
        int first_grant = -1, n_iv = 0, n_dv = 0, t_last = -1, bad_addr = 0, busy = 0, d_first = -1;
        do_reset();
        i_req = 1'b1; i_addr = 16'h0120;
        for (int n = 0; n < 40; n++) begin
            if (t_last >= 0 && n == t_last + 1) begin
                i_req = 1'b0; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0700;
            end
            #1;
            if (i_grant && first_grant < 0) first_grant = n;
            if (i_data_valid) begin n_iv++; if (n_iv == BEATS) t_last = n; end
            if (d_data_valid && t_last < 0) n_dv++;
            if (i_grant && mem_enable && mem_addr != 16'h0120) bad_addr++;
            if (t_last >= 0 && n > t_last && n <= t_last + LATENCY &&
                (i_grant || d_grant || mem_enable || i_data_valid || d_data_valid)) busy++;
            if (t_last >= 0 && n > t_last && d_grant && d_first < 0) d_first = n;
            tick();
        end
        d_req = 1'b0;
        checks++; if (first_grant != 1) begin errors++; $display("FAIL lone_first_grant: got %0d expected 1", first_grant); end
        checks++; if (n_iv != BEATS) begin errors++; $display("FAIL lone_i_valids: got %0d expected %0d", n_iv, BEATS); end
        checks++; if (t_last != LATENCY + BEATS) begin errors++; $display("FAIL lone_last_beat: got %0d expected %0d", t_last, LATENCY + BEATS); end
        checks++; if (n_dv != 0) begin errors++; $display("FAIL lone_d_valids: got %0d expected 0", n_dv); end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL lone_mem_addr: got %0d bad cycles expected 0", bad_addr); end
        checks++; if (busy != 0) begin errors++; $display("FAIL lone_drain_quiet: got %0d active cycles expected 0", busy); end
        checks++; if (d_first != t_last + LATENCY + 1) begin errors++; $display("FAIL lone_next_grant: got %0d expected %0d", d_first, t_last + LATENCY + 1); end
    endtask

    task automatic test_tie_after_reset();
        logic g_i1 = 1'bx, g_d1 = 1'bx, d_at_i = 1'bx;
        int n_dv = 0, t_dlast = -1, i_first = -1, i_dv_in_d = 0;
        do_reset();
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0; i_addr = 16'h0200; d_addr = 16'h0300;
        for (int n = 0; n < 30; n++) begin
            #1;
            if (n == 1) begin g_i1 = i_grant; g_d1 = d_grant; end
            if (d_data_valid) begin n_dv++; if (n_dv == BEATS) t_dlast = n; end
            if (t_dlast < 0 && i_data_valid) i_dv_in_d++;
            if (t_dlast >= 0 && i_first < 0 && i_grant) begin i_first = n; d_at_i = d_grant; end
            tick();
        end
        checks++; if (g_d1 !== 1'b1) begin errors++; $display("FAIL tie_d_grant: got %b expected 1", g_d1); end
        checks++; if (g_i1 !== 1'b0) begin errors++; $display("FAIL tie_i_grant: got %b expected 0", g_i1); end
        checks++; if (t_dlast != LATENCY + BEATS) begin errors++; $display("FAIL tie_d_last: got %0d expected %0d", t_dlast, LATENCY + BEATS); end
        checks++; if (i_dv_in_d != 0) begin errors++; $display("FAIL tie_i_valid_leak: got %0d expected 0", i_dv_in_d); end
        checks++; if (i_first != t_dlast + LATENCY + 1) begin errors++; $display("FAIL tie_i_after: got %0d expected %0d", i_first, t_dlast + LATENCY + 1); end
        checks++; if (d_at_i !== 1'b0) begin errors++; $display("FAIL tie_d_regrant: got %b expected 0", d_at_i); end
    endtask

    task automatic test_store_during_fill();
        int n_iv = 0, t_last = -1, n_wr = 0, wr_cycle = -1;
        bit raised = 0, seen = 0;
        logic [15:0] wr_addr = 'x, wr_data = 'x;
        logic wr_grant = 1'bx;
        do_reset();
        i_req = 1'b1; i_addr = 16'h0120;
        for (int n = 0; n < 26; n++) begin
            if (n_iv == 3 && !raised) begin
                d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h4002; d_wdata = 16'hBEEF; raised = 1;
            end
            if (t_last >= 0) i_req = 1'b0;
            if (seen) d_req = 1'b0;
            #1;
            if (i_data_valid) begin n_iv++; if (n_iv == BEATS) t_last = n; end
            if (mem_wr) begin
                n_wr++; wr_cycle = n; wr_addr = mem_addr; wr_data = mem_wdata; wr_grant = d_grant & mem_enable;
            end
            if (d_grant) seen = 1;
            tick();
        end
        d_wr = 1'b0;
        checks++; if (n_wr != 1) begin errors++; $display("FAIL store_count: got %0d expected 1", n_wr); end
        checks++; if (wr_cycle != t_last + LATENCY + 1) begin errors++; $display("FAIL store_cycle: got %0d expected %0d", wr_cycle, t_last + LATENCY + 1); end
        checks++; if (wr_addr !== 16'h4002) begin errors++; $display("FAIL store_addr: got %h expected 4002", wr_addr); end
        checks++; if (wr_data !== 16'hBEEF) begin errors++; $display("FAIL store_data: got %h expected beef", wr_data); end
        checks++; if (wr_grant !== 1'b1) begin errors++; $display("FAIL store_grant: got %b expected 1", wr_grant); end
    endtask

    task automatic test_stale_drain();
        int rise = 0, n1 = 0, n2 = 0, len2 = 0, t_last1 = -1, stale = 0;
        logic prev = 1'b0;
        do_reset();
        i_req = 1'b1; i_addr = 16'h0AA0;
        for (int n = 0; n < 32; n++) begin
            inject = (t_last1 >= 0 && n == t_last1 + 2);
            #1;
            if (i_grant && !prev) rise++;
            prev = i_grant;
            if (t_last1 >= 0 && n > t_last1 && n <= t_last1 + LATENCY && (i_data_valid || d_data_valid)) stale++;
            if (i_data_valid && rise == 1) begin n1++; if (n1 == BEATS) t_last1 = n; end
            if (i_data_valid && rise == 2) n2++;
            if (i_grant && rise == 2) len2++;
            tick();
        end
        inject = 1'b0; i_req = 1'b0;
        checks++; if (stale != 0) begin errors++; $display("FAIL stale_valid: got %0d expected 0", stale); end
        checks++; if (n2 != BEATS) begin errors++; $display("FAIL stale_next_beats: got %0d expected %0d", n2, BEATS); end
        checks++; if (len2 != LATENCY + BEATS) begin errors++; $display("FAIL stale_next_len: got %0d expected %0d", len2, LATENCY + BEATS); end
    endtask

    task automatic test_reset_mid_fill();
        int n_dv = 0, rst_cycle = -1, i_first = -1, n_iv = 0, len = 0;
        bit did_rst = 0;
        logic [7:0] after = 'x;
        do_reset();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0800; i_addr = 16'h0900;
        for (int n = 0; n < 27; n++) begin
            if (n_dv == 5 && !did_rst) begin
                rst_n = 1'b0; did_rst = 1; rst_cycle = n;
            end else if (did_rst && !rst_n) begin
                rst_n = 1'b1; d_req = 1'b0; i_req = 1'b1;
            end
            #1;
            if (d_data_valid) n_dv++;
            if (did_rst && n == rst_cycle + 1)
                after = {i_grant, d_grant, i_data_valid, d_data_valid, mem_enable, mem_wr, |mem_addr, |mem_wdata};
            if (did_rst && i_grant && i_first < 0) i_first = n;
            if (did_rst && i_grant) len++;
            if (did_rst && i_data_valid) n_iv++;
            tick();
        end
        i_req = 1'b0;
        checks++; if (after !== 8'h00) begin errors++; $display("FAIL rstmid_outputs: got %b expected 00000000", after); end
        checks++; if (i_first != rst_cycle + 2) begin errors++; $display("FAIL rstmid_i_grant: got %0d expected %0d", i_first, rst_cycle + 2); end
        checks++; if (n_iv != BEATS) begin errors++; $display("FAIL rstmid_i_beats: got %0d expected %0d", n_iv, BEATS); end
        checks++; if (len != LATENCY + BEATS) begin errors++; $display("FAIL rstmid_i_len: got %0d expected %0d", len, LATENCY + BEATS); end
    endtask

    task automatic test_back_to_back();
        logic exp_wr;
        do_reset();
        for (int n = 0; n < 6; n++) begin
            d_req = (n < 4); d_wr = 1'b1;
            d_addr = 16'h5000 + 16'(n); d_wdata = 16'h1000 + 16'(n);
            #1;
            exp_wr = (n == 1 || n == 3);
            checks++; if (mem_wr !== exp_wr) begin errors++; $display("FAIL b2b_mem_wr[%0d]: got %b expected %b", n, mem_wr, exp_wr); end
            if (exp_wr) begin
                checks++; if (mem_addr !== 16'h5000 + 16'(n)) begin errors++; $display("FAIL b2b_addr[%0d]: got %h expected %h", n, mem_addr, 16'h5000 + 16'(n)); end
                checks++; if (mem_wdata !== 16'h1000 + 16'(n)) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", n, mem_wdata, 16'h1000 + 16'(n)); end
            end
            tick();
        end
        d_wr = 1'b0;
    endtask

    task automatic test_random();
        rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) i_req = ~i_req;
            if (!d_req) begin
                if ($urandom_range(0, 5) == 0) begin d_req = 1'b1; d_wr = ($urandom_range(0, 2) == 0); end
            end else if (d_grant && $urandom_range(0, 1) == 0) begin
                d_req = 1'b0;
            end
            i_addr  = 16'($urandom);
            d_addr  = 16'($urandom);
            d_wdata = 16'($urandom);
            inject  = ($urandom_range(0, 15) == 0);
            rst_n   = ($urandom_range(0, 299) != 0);
            #1;
            model_expect();
            checks++; if (i_grant !== e_i_grant) begin errors++; $display("FAIL rnd_i_grant @%0d: got %b expected %b", n, i_grant, e_i_grant); end
            checks++; if (d_grant !== e_d_grant) begin errors++; $display("FAIL rnd_d_grant @%0d: got %b expected %b", n, d_grant, e_d_grant); end
            checks++; if (mem_enable !== e_mem_enable) begin errors++; $display("FAIL rnd_mem_enable @%0d: got %b expected %b", n, mem_enable, e_mem_enable); end
            checks++; if (mem_wr !== e_mem_wr) begin errors++; $display("FAIL rnd_mem_wr @%0d: got %b expected %b", n, mem_wr, e_mem_wr); end
            checks++; if (mem_addr !== e_mem_addr) begin errors++; $display("FAIL rnd_mem_addr @%0d: got %h expected %h", n, mem_addr, e_mem_addr); end
            checks++; if (mem_wdata !== e_mem_wdata) begin errors++; $display("FAIL rnd_mem_wdata @%0d: got %h expected %h", n, mem_wdata, e_mem_wdata); end
            checks++; if (i_data_valid !== e_i_dv) begin errors++; $display("FAIL rnd_i_dv @%0d: got %b expected %b", n, i_data_valid, e_i_dv); end
            checks++; if (d_data_valid !== e_d_dv) begin errors++; $display("FAIL rnd_d_dv @%0d: got %b expected %b", n, d_data_valid, e_d_dv); end
            tick();
        end
        inject = 1'b0;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_lone_i_fill();
        test_tie_after_reset();
        test_store_during_fill();
        test_stale_drain();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
